// File: rtl/uart_pkg.sv
// Shared types and helpers for the hex-formatting UART transmitter.
// Holds the formatter state encoding, ASCII control codes and character selection.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } hex_tx_state_t;

  localparam logic [7:0]  ASCII_CR   = 8'h0D;
  localparam logic [7:0]  ASCII_LF   = 8'h0A;
  localparam int unsigned FRAME_BITS = 10;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    logic [7:0] code;
    if (nib < 4'd10) code = 8'h30 + {4'h0, nib};
    else             code = 8'h37 + {4'h0, nib};
    return code;
  endfunction

  // Character order within one message: high nibble, low nibble, CR, LF.
  function automatic logic [7:0] hex_char(input logic [7:0] value, input logic [1:0] idx);
    logic [7:0] code;
    case (idx)
      2'd0:    code = nibble_to_ascii(value[7:4]);
      2'd1:    code = nibble_to_ascii(value[3:0]);
      2'd2:    code = ASCII_CR;
      default: code = ASCII_LF;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/uart_bit_serializer.sv
// 8N1 frame shifter with baud counter; a load starts the start bit on the next cycle.
// done is high during the final clock of the stop bit.
module uart_bit_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       IDX_LAST = 4'(FRAME_BITS - 1);

  logic [CNT_W-1:0]      baud_cnt;
  logic [3:0]            bit_idx;
  logic [FRAME_BITS-1:0] shifter;
  logic                  bit_end;
  logic                  last_bit;

  assign bit_end  = (baud_cnt == CNT_LAST);
  assign last_bit = (bit_idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '1;
    end else if (load) begin
      busy     <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= {1'b1, data, 1'b0};
    end else if (busy) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (last_bit) begin
          busy    <= 1'b0;
          bit_idx <= '0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          shifter <= {1'b1, shifter[FRAME_BITS-1:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  assign done = busy && bit_end && last_bit;
  assign tx   = busy ? shifter[0] : 1'b1;

endmodule

// File: rtl/uart_hex_tx.sv
// Formats a byte as two uppercase ASCII hex digits (optionally plus CR LF)
// and sends them over an 8N1 UART line with one idle cycle between characters.
module uart_hex_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned APPEND_CRLF  = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Byte_DV,
  input  logic [7:0] i_Byte,
  output logic       o_Ready,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_UART_TX
);

  localparam int unsigned NUM_CHARS = (APPEND_CRLF != 0) ? 4 : 2;

  hex_tx_state_t state;
  hex_tx_state_t state_next;

  logic       accept;
  logic       ser_load;
  logic [7:0] ser_data;
  logic       ser_busy;
  logic       ser_done;
  logic       ser_tx;
  logic [7:0] byte_q;
  logic [2:0] char_idx;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= ST_IDLE;
    else          state <= state_next;
  end

  // LOAD overlaps the first start-bit cycle: the frame is handed to the
  // serializer on the edge that enters LOAD, so no dead cycle is added.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_LOAD;
      ST_LOAD: if (ser_busy) state_next = ST_SEND;
      ST_SEND: if (ser_done) state_next = (char_idx == 3'(NUM_CHARS)) ? ST_DONE : ST_GAP;
      ST_GAP:  state_next = ST_LOAD;
      ST_DONE: state_next = accept ? ST_LOAD : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_Ready  = (state == ST_IDLE) || (state == ST_DONE);
    o_Busy   = (state == ST_LOAD) || (state == ST_SEND) || (state == ST_GAP);
    o_Done   = (state == ST_DONE);
    accept   = i_Byte_DV && o_Ready;
    ser_load = accept || (state == ST_GAP);
    ser_data = (state == ST_GAP) ? hex_char(byte_q, char_idx[1:0]) : hex_char(i_Byte, 2'd0);
  end

  // char_idx names the next character to hand over; the first one goes out on acceptance.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      byte_q   <= '0;
      char_idx <= '0;
    end else if (accept) begin
      byte_q   <= i_Byte;
      char_idx <= 3'd1;
    end else if (state == ST_GAP) begin
      char_idx <= char_idx + 3'd1;
    end
  end

  uart_bit_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializer (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .load  (ser_load),
    .data  (ser_data),
    .busy  (ser_busy),
    .done  (ser_done),
    .tx    (ser_tx)
  );

  assign o_UART_TX = ser_tx;

endmodule

// File: doc/uart_hex_tx.md
UART_HEX_TX -- requirements
Module: uart_hex_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, clocks per UART bit (25 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter APPEND_CRLF, default 1, 1 = append CR LF after the two hex characters, 0 = hex characters only.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 i_Clk  input  1  system clock, all logic on rising edge.
REQ-005 i_Rst_L  input  1  asynchronous active-low reset.
REQ-006 i_Byte_DV  input  1  byte valid; accepted only when o_Ready=1.
REQ-007 i_Byte  input  8  binary byte to format and transmit.
REQ-008 o_Ready  output  1  high when idle and able to accept a byte.
REQ-009 o_Busy  output  1  high from acceptance until the o_Done cycle, exclusive.
REQ-010 o_Done  output  1  single-cycle pulse when the last stop bit completes.
REQ-011 o_UART_TX  output  1  serial line, idle high.

Function
REQ-012 SHALL accept a byte on the rising edge where i_Byte_DV=1 and o_Ready=1, latching i_Byte internally; o_Ready low and o_Busy high from the next cycle.
REQ-013 SHALL ignore i_Byte_DV while o_Ready=0, with no queuing and no effect on the latched byte.
REQ-014 SHALL transmit, in order: ASCII of i_Byte[7:4], ASCII of i_Byte[3:0], then 0x0D, 0x0A when APPEND_CRLF=1.
REQ-015 Nibble encoding SHALL be 0x0-0x9 -> 0x30-0x39 and 0xA-0xF -> 0x41-0x46 (uppercase).
REQ-016 Each character SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-017 The first start bit SHALL appear on o_UART_TX in the cycle immediately after acceptance.
REQ-018 Between consecutive characters there SHALL be exactly one idle-high cycle after the stop bit, followed by the next start bit.
REQ-019 Total busy time SHALL be N*10*CLKS_PER_BIT + (N-1) cycles, N = 4 (APPEND_CRLF=1) or 2.
REQ-020 o_Done SHALL pulse high for exactly one cycle, in the cycle after the last stop bit ends; o_Ready SHALL rise in that same cycle.
REQ-021 A new byte MAY be accepted in the o_Done cycle; its start bit then follows on the next cycle.
REQ-022 Control FSM states SHALL be IDLE -> LOAD (select the next character) -> SEND (serializer active) -> GAP (one idle cycle) -> LOAD, or -> DONE after the last character, then DONE -> IDLE.
REQ-023 Bit counter SHALL count 0..CLKS_PER_BIT-1 and wrap; its width SHALL be $clog2(CLKS_PER_BIT).
REQ-024 o_UART_TX SHALL be 1 in every state other than SEND.

Reset
REQ-025 While i_Rst_L=0, outputs SHALL be o_UART_TX=1, o_Ready=1, o_Busy=0, o_Done=0; the FSM SHALL be in IDLE and all counters SHALL be 0, asynchronously.
REQ-026 Reset asserted mid-character SHALL return the line high immediately; after reset deassertion no remaining characters are sent, and o_Done is not pulsed.

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state encoding, the ASCII_CR (0x0D) and ASCII_LF (0x0A) constants, and a nibble-to-ASCII function.
REQ-028 The 10-bit frame shifter and baud counter SHALL be one sub-module, uart_bit_serializer (load/byte in, busy/done/serial out), instantiated once; the formatter FSM stays in uart_hex_tx.

Verification (CLKS_PER_BIT=4)
REQ-029 Send 0x3A -> line carries 0x33, 0x41, 0x0D, 0x0A; o_Done exactly 163 cycles after acceptance.
REQ-030 Send 0x00 then 0xFF, the second asserted in the o_Done cycle -> "00\r\n" then "FF\r\n", with no idle gap beyond REQ-018/021.
REQ-031 Pulse i_Byte_DV with 0x55 during the second character of 0x12 -> only "12\r\n" sent, o_Done pulses once.
REQ-032 Assert i_Rst_L low during the third data bit of the first character of 0xC4 -> o_UART_TX=1 in the same cycle, o_Ready=1, no further start bits, no o_Done.
REQ-033 APPEND_CRLF=0, send 0x9B -> 0x39, 0x42 only; o_Done 81 cycles after acceptance.
REQ-034 Sample every bit at mid-bit with an independent UART RX model -> zero framing errors across all 256 byte values.
